// File: rtl/mnist_io_pkg.sv
// Shared constants, FSM state type and beat-count helper for the MNIST input front end.
package mnist_io_pkg;

  localparam int PIXEL_W    = 8;
  localparam int NUM_PIXELS = 784;
  localparam int IMG_DIM    = 28;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  function automatic int beats(input int num_pixels, input int in_pix);
    return num_pixels / in_pix;
  endfunction

endpackage

// File: rtl/pixel_threshold_lane.sv
// One pixel lane: unsigned compare of a grayscale pixel against the binarization threshold.
module pixel_threshold_lane #(
  parameter int PIXEL_W = mnist_io_pkg::PIXEL_W,
  parameter int THRESH  = 128
) (
  input  logic [PIXEL_W-1:0] pixel_i,
  output logic               bit_o
);

  assign bit_o = (pixel_i >= PIXEL_W'(THRESH));

endmodule

// File: rtl/mnist_input_binarizer.sv
// Collects a streamed MNIST frame, thresholds each pixel to one bit and holds the
// packed activation vector until the first LUT layer takes it.
module mnist_input_binarizer #(
  parameter int PIXEL_W    = mnist_io_pkg::PIXEL_W,
  parameter int IN_PIX     = 4,
  parameter int NUM_PIXELS = mnist_io_pkg::NUM_PIXELS,
  parameter int THRESH     = 128
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [IN_PIX*PIXEL_W-1:0]   in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_PIXELS-1:0]       out_bits,
  output logic [15:0]                 frame_cnt,
  output logic                        err_len
);

  import mnist_io_pkg::*;

  localparam int BEATS = beats(NUM_PIXELS, IN_PIX);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [NUM_PIXELS-1:0]   bits_q, bits_d;
  logic [15:0]             frame_cnt_q, frame_cnt_d;
  logic                    err_q, err_d;
  logic [IN_PIX-1:0]       lane_bits;
  logic                    accept;

  for (genvar j = 0; j < IN_PIX; j++) begin : g_lane
    pixel_threshold_lane #(
      .PIXEL_W (PIXEL_W),
      .THRESH  (THRESH)
    ) u_lane (
      .pixel_i (in_data[j*PIXEL_W +: PIXEL_W]),
      .bit_o   (lane_bits[j])
    );
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign accept    = in_valid && in_ready;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    cnt_d       = cnt_q;
    bits_d      = bits_q;
    frame_cnt_d = frame_cnt_q;
    err_d       = 1'b0;

    case (state_q)
      COLLECT: begin
        if (accept) begin
          // Constant slice bases keep the write a plain decode of the beat counter.
          for (int b = 0; b < BEATS; b++) begin
            if (cnt_q == CNT_W'(b)) bits_d[b*IN_PIX +: IN_PIX] = lane_bits;
          end

          if (cnt_q == LAST_BEAT) begin
            state_d = HOLD;
            cnt_d   = '0;
            err_d   = !in_last;
          end else if (in_last) begin
            // Short frame: drop it; stale bits are overwritten by the next frame.
            cnt_d = '0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      HOLD: begin
        if (out_ready) begin
          state_d     = COLLECT;
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= COLLECT;
      cnt_q       <= '0;
      // NOTE: the packed frame is a flop bank, not a RAM, so it is cleared on reset like all other state.
      bits_q      <= '0;
      frame_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bits_q      <= bits_d;
      frame_cnt_q <= frame_cnt_d;
      err_q       <= err_d;
    end
  end

  assign out_bits  = bits_q;
  assign frame_cnt = frame_cnt_q;
  assign err_len   = err_q;

endmodule
